// File: rtl/cl_demux_pkg.sv
// rtl/cl_demux_pkg.sv - select codes and select legality helper for cl_demux2
package cl_demux_pkg;

  localparam logic [1:0] SEL_PORT0 = 2'b01;
  localparam logic [1:0] SEL_PORT1 = 2'b10;

  function automatic logic is_legal_sel(input logic [1:0] sel);
    return (sel == SEL_PORT0) || (sel == SEL_PORT1);
  endfunction

endpackage

// File: rtl/cl_slot_reg.sv
// rtl/cl_slot_reg.sv - one-entry valid/ready output register
module cl_slot_reg #(
  parameter int DATA_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_free
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  // Free when empty or draining this cycle, so a refill never leaves a bubble.
  assign o_free  = ~r_valid | i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cl_demux2.sv
// rtl/cl_demux2.sv - 1-to-2 stream distributor with one-hot select and drop counter
module cl_demux2
  import cl_demux_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [1:0]            i_sel,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid0,
  input  logic                  i_ready0,
  output logic [DATA_WIDTH-1:0] o_data0,
  output logic                  o_valid1,
  input  logic                  i_ready1,
  output logic [DATA_WIDTH-1:0] o_data1,
  output logic [CNT_WIDTH-1:0]  o_drop_cnt,
  output logic                  o_busy
);

  logic                 w_legal;
  logic                 w_free0;
  logic                 w_free1;
  logic                 w_load0;
  logic                 w_load1;
  logic                 w_drop;
  logic [CNT_WIDTH-1:0] r_drop_cnt;

  assign w_legal = is_legal_sel(i_sel);

  // Only the selected slot's readiness gates acceptance; illegal words are always taken.
  always_comb begin
    o_ready = 1'b1;
    if (i_sel == SEL_PORT0)      o_ready = w_free0;
    else if (i_sel == SEL_PORT1) o_ready = w_free1;
  end

  assign w_load0 = i_valid && (i_sel == SEL_PORT0) && w_free0;
  assign w_load1 = i_valid && (i_sel == SEL_PORT1) && w_free1;
  assign w_drop  = i_valid && !w_legal;

  cl_slot_reg #(.DATA_WIDTH(DATA_WIDTH)) u_slot0 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load0),
    .i_data  (i_data),
    .i_ready (i_ready0),
    .o_valid (o_valid0),
    .o_data  (o_data0),
    .o_free  (w_free0)
  );

  cl_slot_reg #(.DATA_WIDTH(DATA_WIDTH)) u_slot1 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load1),
    .i_data  (i_data),
    .i_ready (i_ready1),
    .o_valid (o_valid1),
    .o_data  (o_data1),
    .o_free  (w_free1)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {CNT_WIDTH{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_drop_cnt = r_drop_cnt;
  assign o_busy     = o_valid0 | o_valid1;

endmodule

// File: tb/tb_cl_demux2.sv
// tb/tb_cl_demux2.sv - scoreboard bench for cl_demux2
module tb_cl_demux2;

  localparam int DW = 5;
  localparam int CW = 8;
  localparam int DROP_MAX = (1 << CW) - 1;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_valid;
  logic          o_ready;
  logic [1:0]    i_sel;
  logic [DW-1:0] i_data;
  logic          o_valid0, o_valid1;
  logic          i_ready0, i_ready1;
  logic [DW-1:0] o_data0, o_data1;
  logic [CW-1:0] o_drop_cnt;
  logic          o_busy;

  cl_demux2 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_sel      (i_sel),
    .i_data     (i_data),
    .o_valid0   (o_valid0),
    .i_ready0   (i_ready0),
    .o_data0    (o_data0),
    .o_valid1   (o_valid1),
    .i_ready1   (i_ready1),
    .o_data1    (o_data1),
    .o_drop_cnt (o_drop_cnt),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] exp_d0, exp_d1;
  int            exp_drop;
  bit            inited = 1'b0;
  bit            last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model at negedge, advance model, step past posedge.
  task automatic cycle();
    logic exp_rdy;
    logic [DW-1:0] w;
    @(negedge i_clk);
    if (i_sel == 2'b01)      exp_rdy = (q0.size() == 0) || i_ready0;
    else if (i_sel == 2'b10) exp_rdy = (q1.size() == 0) || i_ready1;
    else                     exp_rdy = 1'b1;
    if (inited) begin
      chk("ready",  {31'd0, o_ready},  {31'd0, exp_rdy});
      chk("valid0", {31'd0, o_valid0}, {31'd0, q0.size() != 0});
      chk("valid1", {31'd0, o_valid1}, {31'd0, q1.size() != 0});
      chk("data0",  32'(o_data0), 32'(exp_d0));
      chk("data1",  32'(o_data1), 32'(exp_d1));
      chk("drop",   32'(o_drop_cnt), 32'(exp_drop));
      chk("busy",   {31'd0, o_busy}, {31'd0, (q0.size() != 0) || (q1.size() != 0)});
    end
    last_acc = 1'b0;
    if (i_rst) begin
      q0.delete();
      q1.delete();
      exp_d0 = '0;
      exp_d1 = '0;
      exp_drop = 0;
      inited = 1'b1;
    end else if (inited) begin
      if (q0.size() != 0 && i_ready0) begin
        w = q0.pop_front();
        chk("deliver0", 32'(o_data0), 32'(w));
      end
      if (q1.size() != 0 && i_ready1) begin
        w = q1.pop_front();
        chk("deliver1", 32'(o_data1), 32'(w));
      end
      if (i_valid && exp_rdy) begin
        last_acc = 1'b1;
        if (i_sel == 2'b01) begin
          q0.push_back(i_data);
          exp_d0 = i_data;
        end else if (i_sel == 2'b10) begin
          q1.push_back(i_data);
          exp_d1 = i_data;
        end else if (exp_drop < DROP_MAX) begin
          exp_drop++;
        end
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [DW-1:0] d);
    i_valid = v;
    i_sel   = s;
    i_data  = d;
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_sel = 2'b00; i_data = '0;
    i_ready0 = 1'b1; i_ready1 = 1'b1;
    cycle();
    cycle();
    i_rst = 1'b0;
    // reset-state o_ready is 1 for every select code
    for (int s = 0; s < 4; s++) begin
      i_sel = 2'(s);
      #1;
      chk("reset_ready", {31'd0, o_ready}, 32'd1);
    end
    cycle();

    // basic streaming to alternating ports
    drive(1'b1, 2'b01, 5'h0A); cycle();
    drive(1'b1, 2'b10, 5'h0B); cycle();
    drive(1'b1, 2'b01, 5'h0C); cycle();
    drive(1'b0, 2'b00, 5'h00); cycle();
    chk("basic_drop", 32'(o_drop_cnt), 32'd0);
    cycle();

    // port 0 stalled, port 1 still flows
    i_ready0 = 1'b0;
    drive(1'b1, 2'b01, 5'h11); cycle();
    drive(1'b1, 2'b10, 5'h07); cycle();
    drive(1'b0, 2'b00, 5'h00); cycle();
    chk("indep_v0", {31'd0, o_valid0}, 32'd1);
    chk("indep_d1", 32'(o_data1), 32'h07);

    // second word to stalled port waits, then follows with no bubble
    drive(1'b1, 2'b01, 5'h12);
    #1;
    chk("stall_ready", {31'd0, o_ready}, 32'd0);
    cycle();
    cycle();
    chk("stall_hold", 32'(o_data0), 32'h11);
    i_ready0 = 1'b1;
    #1;
    chk("drain_ready", {31'd0, o_ready}, 32'd1);
    cycle();
    drive(1'b0, 2'b00, 5'h00);
    chk("nobubble_v0", {31'd0, o_valid0}, 32'd1);
    chk("nobubble_d0", 32'(o_data0), 32'h12);
    cycle();
    cycle();

    // illegal selects: always accepted, counter saturates
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, (i % 2 == 0) ? 2'b00 : 2'b11, DW'(i));
      #1;
      chk("illegal_ready", {31'd0, o_ready}, 32'd1);
      cycle();
    end
    drive(1'b0, 2'b00, 5'h00);
    cycle();
    chk("drop_sat", 32'(o_drop_cnt), 32'd255);

    // reset with both slots full and stalled
    i_ready0 = 1'b0; i_ready1 = 1'b0;
    drive(1'b1, 2'b01, 5'h15); cycle();
    drive(1'b1, 2'b10, 5'h1E); cycle();
    drive(1'b0, 2'b00, 5'h00);
    chk("full_busy", {31'd0, o_busy}, 32'd1);
    i_rst = 1'b1; cycle();
    i_rst = 1'b0;
    chk("rst_v0",   {31'd0, o_valid0}, 32'd0);
    chk("rst_v1",   {31'd0, o_valid1}, 32'd0);
    chk("rst_d0",   32'(o_data0), 32'd0);
    chk("rst_d1",   32'(o_data1), 32'd0);
    chk("rst_drop", 32'(o_drop_cnt), 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    cycle();

    // random traffic; producer holds a word until it is accepted
    for (int i = 0; i < 10000; i++) begin
      if (!(i_valid && !last_acc)) begin
        i_valid = ($urandom_range(0, 3) != 0);
        i_data  = DW'($urandom);
        case ($urandom_range(0, 15))
          0:       i_sel = 2'b00;
          1:       i_sel = 2'b11;
          2,3,4,5,6,7,8: i_sel = 2'b01;
          default: i_sel = 2'b10;
        endcase
      end
      i_ready0 = ($urandom_range(0, 2) != 0);
      i_ready1 = ($urandom_range(0, 3) == 0);
      cycle();
    end
    drive(1'b0, 2'b00, 5'h00);
    i_ready0 = 1'b1; i_ready1 = 1'b1;
    cycle();
    cycle();
    cycle();
    chk("final_q0", 32'(q0.size()), 32'd0);
    chk("final_busy", {31'd0, o_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cl_demux2.md
# cl_demux2

Clocked 1-to-2 stream distributor with a one-hot select. It is the counterpart of the CL_MUX2 selector: it takes one valid/ready input stream and steers each accepted word to output port 0 or port 1. Each port has a one-entry output register, so the two consumers stall independently. Words carrying an illegal select code are accepted, discarded and counted.

## Interface
- DATA_WIDTH, 5, width of the data word
- CNT_WIDTH, 8, width of the saturating drop counter
- i_clk  input  1  single clock; all state updates on the rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_valid  input  1  producer has a word on i_data/i_sel
- o_ready  output  1  block accepts the word this cycle
- i_sel  input  2  one-hot route: 2'b01 → port 0, 2'b10 → port 1, 2'b00/2'b11 illegal
- i_data  input  DATA_WIDTH  input word
- o_valid0 / o_valid1  output  1  port 0 / port 1 holds a word
- i_ready0 / i_ready1  input  1  consumer 0 / 1 takes the word this cycle
- o_data0 / o_data1  output  DATA_WIDTH  port 0 / port 1 word
- o_drop_cnt  output  CNT_WIDTH  number of illegal-select words dropped, saturating
- o_busy  output  1  o_valid0 | o_valid1

## Operation
- Input handshake is i_valid & o_ready. The producer holds i_data and i_sel stable while i_valid=1 and the word is not yet accepted.
- The slot N register is free when o_validN=0, or when o_validN=1 and i_readyN=1 (it drains this cycle).
- o_ready is combinational:
  - i_sel=01: slot0 free.
  - i_sel=10: slot1 free.
  - illegal i_sel: 1.
- A legal accept loads i_data into o_dataN and sets o_validN.
- An output handshake without a refill clears o_validN. o_dataN holds its last value.
- Drain and refill of the same slot in one cycle: o_validN stays 1 and o_dataN takes the new word. There is no bubble.
- An illegal accept writes no slot. o_drop_cnt increments by 1 and saturates at 2^CNT_WIDTH-1.
- The two slots are independent. Port 1 may pass a word to its consumer while port 0 is stalled. There is no cross-port ordering guarantee.
- o_ready never depends on the unselected port's i_ready.

## Timing
- Reset values: o_valid0=o_valid1=0, o_data0=o_data1=0, o_drop_cnt=0, o_busy=0. o_ready follows the combinational rule from reset state (1 for any i_sel).
- Latency is 1 cycle: a word accepted at edge k is presented on o_dataN with o_validN=1 after edge k.
- Throughput is 1 word/cycle per port while its consumer holds i_readyN=1.
- i_rst asserted mid-operation discards any word held in a slot at the next edge. No handshake completes on that edge.
- There are combinational paths i_readyN → o_ready and i_sel → o_ready. There is no path i_valid → o_ready.
- o_validN must never deassert without an output handshake (except by reset). o_dataN is stable while o_validN=1 & i_readyN=0.

## Structure
- Package cl_demux_pkg:
  - SEL_PORT0=2'b01 and SEL_PORT1=2'b10.
  - Function is_legal_sel(sel).
- Sub-module cl_slot_reg, parameter DATA_WIDTH. It is a one-entry valid/ready register with ports:
  - i_clk, i_rst
  - i_load, i_data, i_ready
  - o_valid, o_data, o_free
- cl_slot_reg is instantiated twice.
- The top level holds the select decode, o_ready, the drop counter and o_busy.

## Test plan
- Reset then stream 01/A, 10/B, 01/C with both i_ready=1 → o_data0=A at cycle 1, o_data1=B at cycle 2, o_data0=C at cycle 3, o_drop_cnt=0.
- Hold i_ready0=0, send 01/5'h11 then 01/5'h12 → second word sees o_ready=0 and o_data0 stays 5'h11. Raise i_ready0 → 5'h12 follows on the next cycle with no bubble.
- Port 0 stalled holding one word, send 10/5'h07 → accepted immediately and o_data1=5'h07 after 1 cycle while o_valid0 stays 1.
- Send i_sel=00 and 11 words, 300 in total, with CNT_WIDTH=8 → o_ready=1 throughout, no o_valid pulse, o_drop_cnt=255.
- Assert i_rst while both slots are full and stalled → next cycle o_valid0=o_valid1=0, o_data0=o_data1=0, o_drop_cnt=0, o_busy=0.
- Random i_sel/i_valid/i_readyN for 10k cycles with a scoreboard → per-port in-order delivery, no loss or duplication, drop count matches the number of illegal words.
